logicnet_lut_layer: RTL and testbench
=====================================

# logicnet_lut_layer

Runtime-loadable, time-multiplexed LogicNet layer engine. It evaluates NEURONS truth-table neurons against one captured input vector, one neuron per cycle, from an internal table memory. Results go out as a single output vector over a valid/ready handshake. It replaces per-neuron hard-coded combinational ROMs in the inference chain, so one bitstream can serve retrained models by reloading the tables.

## Interface
- NEURONS, default 8: neurons per layer; must be ≥ 1.
- ADDR_W, default 6: table address bits per neuron (fan-in × input bits).
- OUT_W, default 2: output bits per neuron.
- CNT_W, default $clog2(NEURONS+1): width of the neuron counter.
- clk  in  1: clock.
- rst  in  1: reset, asynchronous, active-high.
- cfg_we  in  1: table write strobe.
- cfg_neuron  in  CNT_W: neuron index of the table write.
- cfg_addr  in  ADDR_W: table entry being written.
- cfg_data  in  OUT_W: entry value.
- cfg_ready  out  1: high only in IDLE; writes are taken only when cfg_we && cfg_ready.
- s_valid  in  1: input vector valid.
- s_ready  out  1: high only in IDLE.
- s_data  in  NEURONS*ADDR_W: neuron n address is s_data[n*ADDR_W +: ADDR_W].
- m_valid  out  1: output vector valid.
- m_ready  in  1: downstream accept.
- m_data  out  NEURONS*OUT_W: neuron n result is m_data[n*OUT_W +: OUT_W].
- err  out  1: sticky table parity error; tied 0 when parity is compiled out.

## Operation
- Table memory holds NEURONS × 2^ADDR_W words, with 1-cycle registered read latency. Contents are not reset and are undefined until loaded.
- Memory word address = neuron × 2^ADDR_W + entry.
- A write with cfg_neuron ≥ NEURONS is ignored.
- State IDLE: s_ready = cfg_ready = 1, m_valid = 0.
  - On s_valid, capture s_data into the input register, clear the counter, go to EVAL.
  - If cfg_we and s_valid are high in the same cycle, both are accepted. The write lands before the first read is issued.
- State EVAL: each cycle, issue a read for neuron cnt and increment cnt.
  - The read data for neuron k is written into m_data slice k one cycle later.
  - After the read for neuron NEURONS−1 is issued, go to FLUSH.
- State FLUSH: one cycle to land the last result. Then go to OUT.
- State OUT: m_valid = 1. m_data and the input register are held stable until m_ready.
  - On m_valid && m_ready, go to IDLE.
  - s_ready stays 0 in OUT; there is no overlap with the next vector.
- Reset values:
  - State = IDLE, cnt = 0, m_data = 0, m_valid = 0, err = 0.
  - s_ready = 1 and cfg_ready = 1 from the first cycle after reset release.
- Reset asserted mid-EVAL or mid-OUT aborts immediately to the reset values above. Table contents are retained.

## Timing
- Vector accepted at edge T0 → m_valid rises at edge T0 + NEURONS + 2.
- With m_ready held high, the next s_ready is at T0 + NEURONS + 3. Throughput is one vector per NEURONS + 3 cycles.
- For NEURONS = 1: EVAL lasts one cycle, then FLUSH. m_valid rises at T0 + 3.
- m_data changes only during EVAL/FLUSH and on reset. It is never modified while m_valid = 1.

## Configuration
- LOGICNET_LUT_PARITY_EN defined:
  - Each table word is OUT_W + 1 bits; the extra bit stores even parity of cfg_data, computed on write.
  - Every EVAL read is checked. A mismatch sets err, which stays set until rst.
  - The faulty data is still passed to m_data.
- Not defined: words are OUT_W bits, there is no check logic, and err is constant 0.

## Test plan
- Reset: assert rst mid-EVAL → next cycle m_valid = 0, m_data = 0, s_ready = 1. After release, the same vector re-run yields correct results with no table reload.
- Load, NEURONS = 8, ADDR_W = 6, OUT_W = 2:
  - Stimulus: load table n with entry = (addr + n) mod 4; send s_data with every slice = 6'b000011.
  - Required response: m_valid at T0 + 10, and slice n = (3 + n) mod 4.
- Backpressure: hold m_ready = 0 for 20 cycles → m_data stable and s_ready = 0 throughout. Vector accepted on the m_ready cycle; s_ready high on the next cycle.
- Config gating:
  - cfg_we during EVAL → ignored; outputs unchanged on re-run.
  - cfg_we together with s_valid in IDLE → the new entry is used in that same evaluation.
  - cfg_neuron = NEURONS → no memory change.
- Parity (macro on): force-flip one stored bit via a hierarchical deposit, then evaluate that entry → err = 1 and stays 1 across later vectors until rst. Macro off: err = 0 always.
- NEURONS = 1 build: single vector → m_valid at T0 + 3 with the correct 2-bit result.

Source files
------------

// File: rtl/logicnet_lut_if.sv
// Handshake bundle for logicnet_lut_layer: table-load port, input vector stream
// and output vector stream. The DUT takes the slave side; the feeder takes master.
interface logicnet_lut_if #(
  parameter int NEURONS = 8,
  parameter int ADDR_W  = 6,
  parameter int OUT_W   = 2,
  parameter int CNT_W   = $clog2(NEURONS + 1)
);
  logic                      cfg_we;
  logic [CNT_W-1:0]          cfg_neuron;
  logic [ADDR_W-1:0]         cfg_addr;
  logic [OUT_W-1:0]          cfg_data;
  logic                      cfg_ready;
  logic                      s_valid;
  logic                      s_ready;
  logic [NEURONS*ADDR_W-1:0] s_data;
  logic                      m_valid;
  logic                      m_ready;
  logic [NEURONS*OUT_W-1:0]  m_data;

  modport master (
    output cfg_we, cfg_neuron, cfg_addr, cfg_data, s_valid, s_data, m_ready,
    input  cfg_ready, s_ready, m_valid, m_data
  );

  modport slave (
    input  cfg_we, cfg_neuron, cfg_addr, cfg_data, s_valid, s_data, m_ready,
    output cfg_ready, s_ready, m_valid, m_data
  );
endinterface

// File: rtl/logicnet_lut_layer.sv
// Time-multiplexed LogicNet layer: one truth-table neuron evaluated per cycle from
// a runtime-loadable table RAM. Optional table parity check: LOGICNET_LUT_PARITY_EN.
module logicnet_lut_layer #(
  parameter int NEURONS = 8,
  parameter int ADDR_W  = 6,
  parameter int OUT_W   = 2,
  parameter int CNT_W   = $clog2(NEURONS + 1)
) (
  input  logic           clk,
  input  logic           rst,
  logicnet_lut_if.slave  bus,
  output logic           err
);

  localparam int DEPTH  = NEURONS << ADDR_W;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef LOGICNET_LUT_PARITY_EN
  localparam int WORD_W = OUT_W + 1;
`else
  localparam int WORD_W = OUT_W;
`endif

  typedef enum logic [1:0] {IDLE, EVAL, FLUSH, OUT} state_e;

  state_e                   state;
  logic [CNT_W-1:0]         cnt;
  logic                     rdy;
  logic                     m_vld;
  logic [ADDR_W-1:0]        in_p0 [NEURONS];
  logic [ADDR_W-1:0]        sel_addr;
  logic [MEM_AW-1:0]        wr_addr;
  logic [MEM_AW-1:0]        rd_addr;
  logic                     wr_en;
  logic                     rd_en;
  logic [WORD_W-1:0]        wr_word;
  logic [WORD_W-1:0]        mem [DEPTH];
  logic [WORD_W-1:0]        rdata_p1;
  logic [CNT_W-1:0]         idx_p1;
  logic                     vld_p1;
  logic [NEURONS*OUT_W-1:0] m_data_p2;

`ifdef LOGICNET_LUT_PARITY_EN
  function automatic logic par_bit(input logic [OUT_W-1:0] d);
    return ^d;
  endfunction

  assign wr_word = {par_bit(bus.cfg_data), bus.cfg_data};
`else
  assign wr_word = bus.cfg_data;
`endif

  assign bus.s_ready   = rdy;
  assign bus.cfg_ready = rdy;
  assign bus.m_valid   = m_vld;
  assign bus.m_data    = m_data_p2;

  // Out-of-range neuron indices would alias into low tables after truncation.
  assign wr_en   = bus.cfg_we && rdy && (bus.cfg_neuron < CNT_W'(NEURONS));
  assign rd_en   = (state == EVAL);
  assign wr_addr = MEM_AW'({bus.cfg_neuron, bus.cfg_addr});
  assign rd_addr = MEM_AW'({cnt, sel_addr});

  always_comb begin
    sel_addr = '0;
    for (int n = 0; n < NEURONS; n++)
      if (cnt == CNT_W'(n)) sel_addr = in_p0[n];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rdy    <= 1'b1;
      m_vld  <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= rd_en;
      case (state)
        IDLE: if (bus.s_valid) begin
          state <= EVAL;
          cnt   <= '0;
          rdy   <= 1'b0;
        end
        EVAL: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(NEURONS - 1)) state <= FLUSH;
        end
        FLUSH: begin
          state <= OUT;
          m_vld <= 1'b1;
        end
        OUT: if (bus.m_ready) begin
          state <= IDLE;
          cnt   <= '0;
          m_vld <= 1'b0;
          rdy   <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // p0: input vector capture, held until the next accept
  always_ff @(posedge clk) begin
    if (rdy && bus.s_valid)
      for (int n = 0; n < NEURONS; n++)
        in_p0[n] <= bus.s_data[n*ADDR_W +: ADDR_W];
  end

  // p1: table RAM, registered read; loads and evaluations never share a cycle
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_word;
    if (rd_en) begin
      rdata_p1 <= mem[rd_addr];
      idx_p1   <= cnt;
    end
  end

  // p2: land each neuron result into its output slice
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data_p2 <= '0;
    end else if (vld_p1) begin
      for (int n = 0; n < NEURONS; n++)
        if (idx_p1 == CNT_W'(n)) m_data_p2[n*OUT_W +: OUT_W] <= rdata_p1[OUT_W-1:0];
    end
  end

`ifdef LOGICNET_LUT_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     err <= 1'b0;
    else if (vld_p1 && ^rdata_p1) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_logicnet_lut_layer.sv
// Directed bench for logicnet_lut_layer (NEURONS=8, ADDR_W=6, OUT_W=2): table load,
// latency, backpressure, config gating, mid-evaluation reset, parity flag.
module tb_logicnet_lut_layer;
  localparam int N      = 8;
  localparam int ADDR_W = 6;
  localparam int OUT_W  = 2;
  localparam int CNT_W  = $clog2(N + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  logicnet_lut_if #(.NEURONS(N), .ADDR_W(ADDR_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) bus ();

  logicnet_lut_layer #(.NEURONS(N), .ADDR_W(ADDR_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .err (err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input int n, input int a, input int d);
    bus.cfg_we     = 1'b1;
    bus.cfg_neuron = CNT_W'(n);
    bus.cfg_addr   = ADDR_W'(a);
    bus.cfg_data   = OUT_W'(d);
    @(posedge clk); #1;
    bus.cfg_we     = 1'b0;
  endtask

  // Present a vector for one edge, then count edges until m_valid (bounded).
  task automatic run_vec(input logic [N*ADDR_W-1:0] vec, output int lat);
    bus.s_valid = 1'b1;
    bus.s_data  = vec;
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    lat = 1;
    while (!bus.m_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic accept();
    bus.m_ready = 1'b1;
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
  endtask

  logic [N*ADDR_W-1:0] vec_a, vec_b;
  logic [ADDR_W-1:0]   addrs_b [N];
  logic [N*OUT_W-1:0]  held;
  int                  lat;

  initial begin
    bus.cfg_we = 0; bus.cfg_neuron = '0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.s_valid = 0; bus.s_data = '0; bus.m_ready = 0;
    addrs_b = '{6'd63, 6'd0, 6'd5, 6'd10, 6'd17, 6'd33, 6'd2, 6'd48};
    for (int n = 0; n < N; n++) begin
      vec_a[n*ADDR_W +: ADDR_W] = 6'b000011;
      vec_b[n*ADDR_W +: ADDR_W] = addrs_b[n];
    end

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_s_ready",   64'(bus.s_ready),   64'd1);
    check("reset_cfg_ready", 64'(bus.cfg_ready), 64'd1);
    check("reset_m_valid",   64'(bus.m_valid),   64'd0);
    check("reset_m_data",    64'(bus.m_data),    64'd0);
    check("reset_err",       64'(err),           64'd0);

    // Table n entry a = (a + n) mod 4
    for (int n = 0; n < N; n++)
      for (int a = 0; a < (1 << ADDR_W); a++)
        cfg_write(n, a, (a + n) % 4);

    // All slices address 3: slice n = (3+n) mod 4 -> 3,0,1,2,3,0,1,2
    run_vec(vec_a, lat);
    check("latency_a", 64'(lat), 64'd10);
    check("data_a", 64'(bus.m_data), 64'h9393);
    check("out_s_ready", 64'(bus.s_ready), 64'd0);
    accept();
    check("post_accept_m_valid", 64'(bus.m_valid), 64'd0);
    check("post_accept_s_ready", 64'(bus.s_ready), 64'd1);

    // Mixed addresses: slices 3,1,3,1,1,2,0,3
    run_vec(vec_b, lat);
    check("latency_b", 64'(lat), 64'd10);
    check("data_b", 64'(bus.m_data), 64'hC977);
    accept();

    // Backpressure: 20 cycles of m_ready low
    run_vec(vec_a, lat);
    held = bus.m_data;
    check("bp_data_first", 64'(held), 64'h9393);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("bp_stall", {61'd0, bus.m_valid, bus.s_ready, (bus.m_data === 16'h9393)}, 64'b101);
    end
    accept();
    check("bp_release_s_ready", 64'(bus.s_ready), 64'd1);

    // Write attempted during EVAL is dropped
    bus.s_valid = 1'b1; bus.s_data = vec_a;
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    check("eval_cfg_ready", 64'(bus.cfg_ready), 64'd0);
    cfg_write(0, 3, 0);
    lat = 2;
    while (!bus.m_valid && lat < 64) begin @(posedge clk); #1; lat++; end
    check("eval_write_ignored", 64'(bus.m_data), 64'h9393);
    accept();
    run_vec(vec_a, lat);
    check("eval_write_rerun", 64'(bus.m_data), 64'h9393);
    accept();

    // Write together with s_valid: the new entry is used immediately
    bus.cfg_we = 1'b1; bus.cfg_neuron = 0; bus.cfg_addr = 3; bus.cfg_data = 0;
    run_vec(vec_a, lat);
    bus.cfg_we = 1'b0;
    check("same_cycle_latency", 64'(lat), 64'd10);
    check("same_cycle_write", 64'(bus.m_data), 64'h9390);
    accept();
    cfg_write(0, 3, 3);

    // cfg_neuron == NEURONS must not alias onto neuron 0
    cfg_write(N, 3, 0);
    run_vec(vec_a, lat);
    check("oob_neuron_ignored", 64'(bus.m_data), 64'h9393);
    accept();

    // Reset mid-EVAL, then re-run without reloading
    bus.s_valid = 1'b1; bus.s_data = vec_b;
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_m_valid", 64'(bus.m_valid), 64'd0);
    check("midrst_m_data",  64'(bus.m_data),  64'd0);
    check("midrst_s_ready", 64'(bus.s_ready), 64'd1);
    @(posedge clk); #1 rst = 1'b0;
    run_vec(vec_b, lat);
    check("midrst_rerun_latency", 64'(lat), 64'd10);
    check("midrst_rerun_data", 64'(bus.m_data), 64'hC977);
    accept();

`ifdef LOGICNET_LUT_PARITY_EN
    // Flip stored data bit of neuron 0, entry 3
    dut.mem[3] = dut.mem[3] ^ 3'b001;
    run_vec(vec_a, lat);
    check("parity_err_set", 64'(err), 64'd1);
    check("parity_data_passed", 64'(bus.m_data), 64'h9392);
    accept();
    run_vec(vec_b, lat);
    check("parity_err_sticky", 64'(err), 64'd1);
    accept();
    #1 rst = 1'b1;
    #1;
    check("parity_err_cleared", 64'(err), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
`else
    check("err_const_zero", 64'(err), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
